// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster timing generator.
//   - default 640x480 @ 60 Hz timing (50 MHz system clock, 2 clocks/pixel)
//   - coord_t: 10-bit pixel/line coordinate
//   - SYNC_ACTIVE: level driven on h_sync/v_sync during the sync pulse
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEFAULT_H_VISIBLE    = 640;
  localparam int DEFAULT_H_FRONT      = 16;
  localparam int DEFAULT_H_SYNC       = 96;
  localparam int DEFAULT_H_BACK       = 48;
  localparam int DEFAULT_V_VISIBLE    = 480;
  localparam int DEFAULT_V_FRONT      = 10;
  localparam int DEFAULT_V_SYNC       = 2;
  localparam int DEFAULT_V_BACK       = 33;
  localparam int DEFAULT_CLOCK_DIVIDE = 2;

  // Both sync pulses are active low for this mode.
  localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   clock, reset  system clock, asynchronous active-low reset
//   advance       step the count on this edge
//   count         current position, 0..TOTAL-1 (registered)
//   wrap          advance while at TOTAL-1 (the count returns to 0 on this edge)
//   sync_n        sync level for the position the count holds after this edge
//   active        position after this edge lies in the visible interval
// sync_n and active are look-ahead decodes so the parent can register them
// alongside the count, keeping every pin glitch-free with zero skew.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               sync_n,
  output logic               active
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t SYNC_START = coord_t'(VISIBLE + FRONT);
  localparam coord_t SYNC_END   = coord_t'(VISIBLE + FRONT + SYNC);
  localparam coord_t VIS_END    = coord_t'(VISIBLE);

  if (TOTAL > (1 << COORD_W)) begin : g_total_check
    $error("vga_axis_counter: total period does not fit the coordinate width");
  end

  coord_t count_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    wrap       = advance && (count == LAST);
    count_next = count;
    if (advance) begin
      count_next = wrap ? '0 : count + coord_t'(1);
    end
    sync_n = ((count_next >= SYNC_START) && (count_next < SYNC_END))
             ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    active = (count_next < VIS_END);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for the VGA output path.
//   clock, reset   system clock, asynchronous active-low reset
//   pixel_enable   high in the last clock of each pixel period
//   pixel_x/y      current horizontal / vertical count
//   pixel_valid    position inside the visible region
//   line_start     pixel_enable at pixel_x==0
//   frame_start    pixel_enable at pixel_x==0, pixel_y==0
//   h_sync/v_sync  sync pulses, active low
//   vga_clock      DAC pixel clock, rising mid-pixel
//   vga_blank      DAC blank, active low (high while visible)
//   vga_sync       DAC sync-on-green, tied low
// All pins come straight from flops loaded with the decode of the next state.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE    = DEFAULT_H_VISIBLE,
  parameter int H_FRONT      = DEFAULT_H_FRONT,
  parameter int H_SYNC       = DEFAULT_H_SYNC,
  parameter int H_BACK       = DEFAULT_H_BACK,
  parameter int V_VISIBLE    = DEFAULT_V_VISIBLE,
  parameter int V_FRONT      = DEFAULT_V_FRONT,
  parameter int V_SYNC       = DEFAULT_V_SYNC,
  parameter int V_BACK       = DEFAULT_V_BACK,
  parameter int CLOCK_DIVIDE = DEFAULT_CLOCK_DIVIDE
) (
  input  logic               clock,
  input  logic               reset,
  output logic               pixel_enable,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pixel_valid,
  output logic               line_start,
  output logic               frame_start,
  output logic               h_sync,
  output logic               v_sync,
  output logic               vga_clock,
  output logic               vga_blank,
  output logic               vga_sync
);

  localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLOCK_DIVIDE / 2);

  if (CLOCK_DIVIDE < 2) begin : g_divide_check
    $error("vga_timing: CLOCK_DIVIDE must be at least 2");
  end

  // The first edge after reset release only loads the decode of (0,0,0);
  // running holds the divider there for that one edge so the first frame is
  // complete and opens with a frame_start.
  logic             running;
  logic [DIV_W-1:0] div, div_next;
  logic             tick;

  logic h_wrap, h_sync_next, h_active_next;
  logic v_wrap, v_sync_next, v_active_next;
  logic h_zero_next, v_zero_next, pix_en_next;

  always_comb begin
    tick = (div == DIV_LAST);
    if (!running || tick) begin
      div_next = '0;
    end else begin
      div_next = div + DIV_W'(1);
    end
    pix_en_next = (div_next == DIV_LAST);
    // An axis sits at 0 after this edge if it wraps now or is at 0 and holds.
    h_zero_next = h_wrap || ((pixel_x == '0) && !tick);
    v_zero_next = v_wrap || ((pixel_y == '0) && !h_wrap);
  end

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clock  (clock),
    .reset  (reset),
    .advance(tick),
    .count  (pixel_x),
    .wrap   (h_wrap),
    .sync_n (h_sync_next),
    .active (h_active_next)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clock  (clock),
    .reset  (reset),
    .advance(h_wrap),
    .count  (pixel_y),
    .wrap   (v_wrap),
    .sync_n (v_sync_next),
    .active (v_active_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      running      <= 1'b0;
      div          <= '0;
      pixel_enable <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      pixel_valid  <= 1'b0;
      vga_blank    <= 1'b0;
      h_sync       <= ~SYNC_ACTIVE;
      v_sync       <= ~SYNC_ACTIVE;
      vga_clock    <= 1'b0;
    end else begin
      running      <= 1'b1;
      div          <= div_next;
      pixel_enable <= pix_en_next;
      line_start   <= pix_en_next && h_zero_next;
      frame_start  <= pix_en_next && h_zero_next && v_zero_next;
      pixel_valid  <= h_active_next && v_active_next;
      vga_blank    <= h_active_next && v_active_next;
      h_sync       <= h_sync_next;
      v_sync       <= v_sync_next;
      vga_clock    <= (div_next >= DIV_HALF);
    end
  end

  assign vga_sync = 1'b0;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: drives two instances (default 640x480 mode and a small
// 8/2/2/2 x 4/1/1/1 mode at divide-by-3) from a shared clock and reset.
// Expected outputs come from a cycle-index model: cycle k after release maps
// to d = k mod CD, pixel p = k / CD, h = p mod H_TOTAL, v = (p / H_TOTAL) mod
// V_TOTAL, and every pin is a plain predicate on (d,h,v). Spec-level interval
// measurements (sync widths, line/frame periods) are checked on top.
module tb_vga_timing;

  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_CD = 2;
  localparam int B_HV = 8,   B_HF = 2,  B_HS = 2,  B_HB = 2;
  localparam int B_VV = 4,   B_VF = 1,  B_VS = 1,  B_VB = 1,  B_CD = 3;

  // {pixel_enable, line_start, frame_start, pixel_valid, h_sync, v_sync,
  //  vga_clock, vga_blank, vga_sync, pixel_x, pixel_y}
  localparam logic [28:0] RESET_OUT = {4'b0000, 2'b11, 3'b000, 20'd0};

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic       a_pe, a_ls, a_fs, a_pv, a_hs, a_vs, a_vc, a_vb, a_sy;
  logic [9:0] a_x, a_y;
  logic       b_pe, b_ls, b_fs, b_pv, b_hs, b_vs, b_vc, b_vb, b_sy;
  logic [9:0] b_x, b_y;

  vga_timing u_dut_a (
    .clock(clock), .reset(reset),
    .pixel_enable(a_pe), .pixel_x(a_x), .pixel_y(a_y), .pixel_valid(a_pv),
    .line_start(a_ls), .frame_start(a_fs), .h_sync(a_hs), .v_sync(a_vs),
    .vga_clock(a_vc), .vga_blank(a_vb), .vga_sync(a_sy)
  );

  vga_timing #(
    .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .CLOCK_DIVIDE(B_CD)
  ) u_dut_b (
    .clock(clock), .reset(reset),
    .pixel_enable(b_pe), .pixel_x(b_x), .pixel_y(b_y), .pixel_valid(b_pv),
    .line_start(b_ls), .frame_start(b_fs), .h_sync(b_hs), .v_sync(b_vs),
    .vga_clock(b_vc), .vga_blank(b_vb), .vga_sync(b_sy)
  );

  wire [28:0] obs_a = {a_pe, a_ls, a_fs, a_pv, a_hs, a_vs, a_vc, a_vb, a_sy, a_x, a_y};
  wire [28:0] obs_b = {b_pe, b_ls, b_fs, b_pv, b_hs, b_vs, b_vc, b_vb, b_sy, b_x, b_y};

  function automatic logic [28:0] model(int k, int hv, int hf, int hs, int hb,
                                        int vv, int vf, int vs, int vb, int cd);
    int ht, vt, d, p, h, v;
    logic pe, ls, fs, vis, hsn, vsn, vclk;
    logic [9:0] hx, vy;
    ht   = hv + hf + hs + hb;
    vt   = vv + vf + vs + vb;
    d    = k % cd;
    p    = k / cd;
    h    = p % ht;
    v    = (p / ht) % vt;
    pe   = (d == cd - 1);
    ls   = pe && (h == 0);
    fs   = ls && (v == 0);
    vis  = (h < hv) && (v < vv);
    hsn  = !((h >= hv + hf) && (h < hv + hf + hs));
    vsn  = !((v >= vv + vf) && (v < vv + vf + vs));
    vclk = (d >= cd / 2);
    hx   = h[9:0];
    vy   = v[9:0];
    return {pe, ls, fs, vis, hsn, vsn, vclk, vis, 1'b0, hx, vy};
  endfunction

  task automatic check(string tag, logic [28:0] observed, logic [28:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_int(string tag, int observed, int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Starts right after reset release (called at a negedge) and compares
  // every cycle for n cycles, plus interval measurements on both instances.
  task automatic run_epoch(int n);
    int a_last_ls = -1, b_last_ls = -1, b_last_fs = -1;
    int a_hs_run = 0, b_hs_run = 0, b_vs_run = 0;
    logic a_hs_prev = 1'b1, b_hs_prev = 1'b1, b_vs_prev = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
      check("default_mode", obs_a, model(k, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_CD));
      check("small_mode",   obs_b, model(k, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_CD));
      if (k == A_CD - 1) check_int("first_frame_start_a", int'(a_fs), 1);
      if (k == B_CD - 1) check_int("first_frame_start_b", int'(b_fs), 1);

      if (a_ls) begin
        if (a_last_ls >= 0) check_int("line_period_a", k - a_last_ls, 1600);
        a_last_ls = k;
      end
      if (!a_hs && a_hs_prev) check_int("hsync_start_x_a", int'(a_x), 656);
      if (!a_hs) a_hs_run++;
      if (a_hs && !a_hs_prev) begin
        check_int("hsync_width_a", a_hs_run, 192);
        a_hs_run = 0;
      end
      a_hs_prev = a_hs;

      if (b_ls) begin
        if (b_last_ls >= 0) check_int("line_period_b", k - b_last_ls, 42);
        b_last_ls = k;
      end
      if (b_fs) begin
        if (b_last_fs >= 0) check_int("frame_period_b", k - b_last_fs, 294);
        b_last_fs = k;
      end
      if (!b_hs && b_hs_prev) check_int("hsync_start_x_b", int'(b_x), 10);
      if (!b_hs) b_hs_run++;
      if (b_hs && !b_hs_prev) begin
        check_int("hsync_width_b", b_hs_run, 6);
        b_hs_run = 0;
      end
      b_hs_prev = b_hs;
      if (!b_vs && b_vs_prev) check_int("vsync_start_b", int'({b_x, b_y}), int'({10'd0, 10'd5}));
      if (!b_vs) b_vs_run++;
      if (b_vs && !b_vs_prev) begin
        check_int("vsync_width_b", b_vs_run, 42);
        b_vs_run = 0;
      end
      b_vs_prev = b_vs;
    end
  endtask

  // Asserts reset between edges, checks the pins react before the next edge,
  // holds reset for a random number of cycles, then releases at a negedge.
  task automatic async_reset();
    int hold;
    @(posedge clock);
    #($urandom_range(3, 1));
    reset = 1'b0;
    #1;
    check("async_reset_a", obs_a, RESET_OUT);
    check("async_reset_b", obs_b, RESET_OUT);
    hold = int'($urandom_range(5, 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("reset_hold_a", obs_a, RESET_OUT);
      check("reset_hold_b", obs_b, RESET_OUT);
    end
    reset = 1'b1;
  endtask

  initial begin
    // Power-on reset for 5 cycles.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("por_a", obs_a, RESET_OUT);
      check("por_b", obs_b, RESET_OUT);
    end
    reset = 1'b1;

    // Several lines of the default mode, many frames of the small mode.
    run_epoch(3400);

    // Random mid-frame asynchronous resets, each followed by a fresh run.
    for (int e = 0; e < 3; e++) begin
      async_reset();
      run_epoch(int'($urandom_range(3300, 300)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
